// File: rtl/wload_fire4_squeeze.sv
`default_nettype none
// ============================================================================
// Module      : wload_fire4_squeeze
// Description : Streaming weight loader for the fire4 squeeze layer. Scatters
//               a valid/ready word stream address-major across NUM banks and
//               serves combinational NUM-wide reads at a shared address.
// Revision    : 1.0 - initial release
// ============================================================================
module wload_fire4_squeeze #(
    parameter int WIDTH = 16,
    parameter int ADDR  = 10,
    parameter int NUM   = 32,
    parameter int DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             busy,
    output logic             done,
    input  logic [ADDR-1:0]  address,
    output logic [WIDTH-1:0] rom_out [0:NUM-1]
);

    localparam int BW = (NUM > 1) ? $clog2(NUM) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   bank_cnt_q, bank_cnt_d;
    logic [ADDR-1:0] addr_cnt_q, addr_cnt_d;
    logic            w_accept;
    logic            w_bank_last;
    logic            w_addr_last;

    assign w_accept    = s_valid && (state_q == S_LOAD);
    assign w_bank_last = (bank_cnt_q == BW'(NUM - 1));
    assign w_addr_last = (addr_cnt_q == ADDR'(DEPTH - 1));

    assign busy    = (state_q == S_LOAD);
    assign done    = (state_q == S_DONE);
    assign s_ready = busy;

    always_comb begin
        state_d    = state_q;
        bank_cnt_d = bank_cnt_q;
        addr_cnt_d = addr_cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    bank_cnt_d = '0;
                    addr_cnt_d = '0;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    if (w_bank_last) begin
                        bank_cnt_d = '0;
                        // Final beat: park the address counter instead of running past DEPTH.
                        if (w_addr_last) begin
                            state_d = S_DONE;
                        end else begin
                            addr_cnt_d = addr_cnt_q + 1'b1;
                        end
                    end else begin
                        bank_cnt_d = bank_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bank_cnt_q <= '0;
            addr_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            bank_cnt_q <= bank_cnt_d;
            addr_cnt_q <= addr_cnt_d;
        end
    end

    genvar b;
    generate
        for (b = 0; b < NUM; b++) begin : g_bank
            (* rom_style = "distributed" *) logic [WIDTH-1:0] mem_q [0:(2**ADDR)-1];

            always_ff @(posedge clk) begin
                if (!rst && w_accept && (bank_cnt_q == BW'(b))) begin
                    mem_q[addr_cnt_q] <= s_data;
                end
            end

            assign rom_out[b] = mem_q[address];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_wload_fire4_squeeze.sv
`default_nettype none
// ============================================================================
// Module      : tb_wload_fire4_squeeze
// Description : Self-checking bench for wload_fire4_squeeze (DEPTH=4, NUM=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wload_fire4_squeeze;

    localparam int WIDTH = 16;
    localparam int ADDR  = 10;
    localparam int NUM   = 32;
    localparam int DEPTH = 4;
    localparam int TOTAL = NUM * DEPTH;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic             busy;
    logic             done;
    logic [ADDR-1:0]  address = '0;
    logic [WIDTH-1:0] rom_out [0:NUM-1];

    int total = 0;
    int bad   = 0;

    wload_fire4_squeeze #(
        .WIDTH(WIDTH), .ADDR(ADDR), .NUM(NUM), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .s_data(s_data),
        .s_valid(s_valid), .s_ready(s_ready), .busy(busy), .done(done),
        .address(address), .rom_out(rom_out)
    );

    always #5 clk = ~clk;

    // Model: a beat counter n; beat n lands at bank n%NUM, address n/NUM.
    logic [WIDTH-1:0] m_mem   [NUM][DEPTH];
    bit               m_known [NUM][DEPTH];
    bit               m_load = 1'b0;
    bit               m_done = 1'b0;
    int               m_n = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_load <= 1'b0;
            m_done <= 1'b0;
        end else if (m_load) begin
            if (s_valid) begin
                m_mem[m_n % NUM][m_n / NUM]   <= s_data;
                m_known[m_n % NUM][m_n / NUM] <= 1'b1;
                m_n <= m_n + 1;
                if (m_n + 1 == TOTAL) begin
                    m_load <= 1'b0;
                    m_done <= 1'b1;
                end
            end
        end else if (start) begin
            m_load <= 1'b1;
            m_done <= 1'b0;
            m_n    <= 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("s_ready", int'(s_ready), int'(m_load));
        chk("busy", int'(busy), int'(m_load));
        chk("done", int'(done), int'(m_done));
        if (int'(address) < DEPTH) begin
            for (int k = 0; k < NUM; k++) begin
                if (m_known[k][address])
                    chk($sformatf("rom_out[%0d]@%0d", k, address),
                        int'(rom_out[k]), int'(m_mem[k][address]));
            end
        end
    end

    // mode: 0 = continuous, 1 = valid pattern 1,0,0; comp selects complement data.
    task automatic do_load(input int base, input bit gaps, input bit comp,
                           input bit start_mid, output int edges, output int beats);
        int cyc;
        bit v;
        edges = 0;
        beats = 0;
        cyc   = 0;
        @(negedge clk);
        start   = 1'b1;
        s_valid = 1'b0;
        @(posedge clk);
        edges++;
        @(negedge clk);
        start = 1'b0;
        while (!done && edges < 2000) begin
            v       = gaps ? (cyc % 3 == 0) : 1'b1;
            s_valid = v;
            s_data  = comp ? ~WIDTH'(beats) : WIDTH'(base + beats);
            start   = start_mid && (beats == 50);
            address = ADDR'(cyc % DEPTH);
            @(posedge clk);
            edges++;
            if (v) beats++;
            @(negedge clk);
            cyc++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        chk("load_terminates", int'(done), 1);
    endtask

    logic [WIDTH-1:0] snap [0:NUM-1];
    int edges, beats;

    initial begin
        #1;
        for (int k = 0; k < NUM; k++) snap[k] = rom_out[k];

        // Reset with start and valid asserted: nothing moves, nothing is written.
        rst = 1'b1; start = 1'b1; s_valid = 1'b1; s_data = 16'hABCD;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_s_ready", int'(s_ready), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
        end
        for (int k = 0; k < NUM; k++)
            chk($sformatf("rst_nowrite[%0d]", k), int'(rom_out[k]), int'(snap[k]));
        rst = 1'b0; start = 1'b0; s_valid = 1'b0;

        // Full continuous load.
        do_load(0, 1'b0, 1'b0, 1'b0, edges, beats);
        chk("full_edges", edges, 129);
        chk("full_beats", beats, 128);
        address = 10'd2;
        #1;
        for (int k = 0; k < NUM; k++)
            chk($sformatf("full_addr2[%0d]", k), int'(rom_out[k]), 64 + k);

        // Extra words offered in DONE are refused.
        @(negedge clk);
        s_valid = 1'b1; s_data = 16'hFFFF;
        for (int c = 0; c < 4; c++) begin
            address = ADDR'(c);
            @(posedge clk);
            @(negedge clk);
            chk("done_s_ready", int'(s_ready), 0);
            chk("done_nowrite_b0", int'(rom_out[0]), 32 * c);
        end
        s_valid = 1'b0;

        // Gapped load with distinct data, then same data back.
        do_load(500, 1'b1, 1'b0, 1'b0, edges, beats);
        chk("gap_beats", beats, 128);
        chk("gap_edges", edges, 1 + 3 * 127 + 1);
        do_load(0, 1'b1, 1'b0, 1'b0, edges, beats);
        address = 10'd3;
        #1;
        chk("gap_addr3_b5", int'(rom_out[5]), 101);

        // Start pulsed mid-load is ignored.
        do_load(0, 1'b0, 1'b0, 1'b1, edges, beats);
        chk("midstart_edges", edges, 129);
        address = 10'd1;
        #1;
        chk("midstart_addr1_b31", int'(rom_out[31]), 63);

        // Reset after 40 beats of a new load.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            s_valid = 1'b1;
            s_data  = WIDTH'(1000 + i);
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1; s_data = 16'h7777;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; s_valid = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        address = 10'd0;
        #1;
        chk("midrst_a0_b0", int'(rom_out[0]), 1000);
        chk("midrst_a0_b31", int'(rom_out[31]), 1031);
        address = 10'd1;
        #1;
        chk("midrst_a1_b7", int'(rom_out[7]), 1039);
        chk("midrst_a1_b8", int'(rom_out[8]), 40);

        // Complement reload.
        do_load(0, 1'b0, 1'b0, 1'b0, edges, beats);
        do_load(0, 1'b0, 1'b1, 1'b0, edges, beats);
        chk("reload_beats", beats, 128);
        address = 10'd3;
        #1;
        chk("reload_a3_b31", int'(rom_out[31]), 32'hFF80);
        address = 10'd0;
        #1;
        chk("reload_a0_b0", int'(rom_out[0]), 32'hFFFF);
        repeat (4) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
